spi_accel_responder: RTL
========================

SPI_ACCEL_RESPONDER -- requirements
Module: spi_accel_responder

Interface
REQ-001 SHALL have parameter CLK_PER_SCLK_MIN, default 8, meaning minimum supported clk cycles per SCLK period (documentation and bench check only).
REQ-002 SHALL have parameter DEVID, default 8'hAD, meaning the value returned at register 0x00.
REQ-003 SHALL have port clk, input, 1 bit, meaning the single system clock; all logic is on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit, meaning a synchronous, active-high reset.
REQ-005 SHALL have port SCLK, input, 1 bit, meaning the SPI clock from the master, asynchronous to clk.
REQ-006 SHALL have port CS, input, 1 bit, meaning the active-low chip select from the master.
REQ-007 SHALL have port MOSI, input, 1 bit, meaning master-to-slave serial data.
REQ-008 SHALL have port MISO, output, 1 bit, meaning slave-to-master serial data.
REQ-009 SHALL have ports X_value, Y_value and Z_value, input, 16 bits each, meaning the sample values presented to the master (two's complement).
REQ-010 SHALL have ports wr_valid (output, 1 bit), wr_addr (output, 8 bits) and wr_data (output, 8 bits), meaning a one-cycle register-write notification.
REQ-011 SHALL have port busy, output, 1 bit, meaning a frame is in progress (synchronized CS is low).

Function
REQ-012 SHALL pass SCLK, CS and MOSI through 2-flop synchronizers; SCLK edges and CS edges SHALL be detected on the synchronized signals.
REQ-013 SHALL use SPI mode 0: MOSI sampled on the detected SCLK rise; MISO updated on the detected SCLK fall; MSB first.
REQ-014 SHALL have FSM states IDLE, CMD, ADDR, RDATA, WDATA and IGNORE.
REQ-015 FSM transitions SHALL be: IDLE->CMD on CS fall; CMD->ADDR after 8 bits if the command is 0x0B (read) or 0x0A (write), otherwise CMD->IGNORE; ADDR->RDATA or ADDR->WDATA after 8 bits; any state->IDLE on CS rise.
REQ-016 SHALL snapshot X_value, Y_value and Z_value on CS fall, so that all reads within one frame are coherent.
REQ-017 SHALL implement this register map: 0x00=DEVID; 0x01=8'h1D; 0x02=8'hF2; 0x0E/0x0F=X low/high; 0x10/0x11=Y low/high; 0x12/0x13=Z low/high; 0x20-0x2F=16 read/write scratch bytes; every other address reads 8'h00.
REQ-018 RDATA SHALL load the addressed byte into the MISO shift register in the same cycle the 8th address bit is sampled, and drive its MSB onto MISO by the next SCLK fall.
REQ-019 RDATA SHALL auto-increment the address after each byte; the address SHALL wrap 8'hFF->8'h00.
REQ-020 WDATA SHALL, on the 8th sampled bit of each byte, write that byte to the register if the address is in 0x20-0x2F.
REQ-021 On that same 8th bit, WDATA SHALL pulse wr_valid for exactly 1 cycle with wr_addr and wr_data, in range only; the address SHALL then auto-increment with wrap.
REQ-022 A write to any other address SHALL be silently discarded, with no wr_valid pulse.
REQ-023 MISO SHALL be 0 in IDLE, CMD, ADDR, WDATA and IGNORE states.
REQ-024 A CS rise mid-byte SHALL discard the partial byte: no write, no wr_valid; the bit counter SHALL clear.
REQ-025 SCLK edges while CS is high SHALL be ignored.
REQ-026 busy SHALL be high from the cycle after synchronized CS falls until the cycle after it rises.
REQ-027 A CS fall and an SCLK rise detected in the same cycle SHALL start the frame and sample that bit as command bit 7.

Reset
REQ-028 On reset SHALL drive: FSM=IDLE; MISO=0; wr_valid=0; wr_addr=0; wr_data=0; busy=0; all shift registers and counters cleared; scratch registers=8'h00; snapshot=0.
REQ-029 Reset SHALL take priority over all other events; reset asserted mid-frame SHALL abort the frame, and the responder SHALL wait for the next CS fall before decoding again.

Verification
REQ-030 Frame 0x0B,0x00 then 3 read bytes, clk=8x SCLK -> MISO bytes 0xAD, 0x1D, 0xF2.
REQ-031 Y_value=16'h1234, frame 0x0B,0x10 then 2 bytes; Y_value changed to 16'hFFFF mid-frame -> MISO bytes 0x34, 0x12.
REQ-032 Frame 0x0A,0x2F,0x55,0x66 -> wr_valid pulses (0x2F,0x55) and (0x30 ignored, no pulse); a following read of 0x2F returns 0x55.
REQ-033 Frame 0x0B,0xFF then 2 bytes -> MISO bytes 0x00, 0xAD (address wrap to 0x00).
REQ-034 Frame 0x0A,0x20 then 5 bits, CS rises -> no wr_valid; register 0x20 stays 0x00; the next frame decodes normally.
REQ-035 Command 0x42, then reset pulsed mid-frame -> MISO=0 and busy=0 throughout; after reset a new 0x0B,0x01 frame returns 0x1D.

Source files
------------

// File: rtl/spi_accel_responder.sv
// spi_accel_responder: SPI mode-0 register slave exposing device ID, coherent XYZ samples and scratch bytes
module spi_accel_responder #(
  parameter int         CLK_PER_SCLK_MIN = 8,
  parameter logic [7:0] DEVID            = 8'hAD
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        SCLK,
  input  logic        CS,
  input  logic        MOSI,
  output logic        MISO,
  input  logic [15:0] X_value,
  input  logic [15:0] Y_value,
  input  logic [15:0] Z_value,
  output logic        wr_valid,
  output logic [7:0]  wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CMD    = 3'd1;
  localparam logic [2:0] S_ADDR   = 3'd2;
  localparam logic [2:0] S_RDATA  = 3'd3;
  localparam logic [2:0] S_WDATA  = 3'd4;
  localparam logic [2:0] S_IGNORE = 3'd5;

  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_WRITE = 8'h0A;

  // The synchronizer plus edge detector needs a few clk cycles per SCLK half period
  if (CLK_PER_SCLK_MIN < 6) begin : g_rate_check
    $error("spi_accel_responder: CLK_PER_SCLK_MIN too small for 2-flop synchronization");
  end

  logic [1:0]  r_sclk_sync;
  logic [1:0]  r_cs_sync;
  logic [1:0]  r_mosi_sync;
  logic        r_sclk_d;
  logic        r_cs_d;
  logic [2:0]  r_state;
  logic [2:0]  r_bit_cnt;
  logic [7:0]  r_shift_in;
  logic [7:0]  r_shift_out;
  logic [7:0]  r_addr;
  logic        r_write;
  logic        r_miso;
  logic        r_busy;
  logic        r_wr_valid;
  logic [7:0]  r_wr_addr;
  logic [7:0]  r_wr_data;
  logic [15:0] r_snap_x;
  logic [15:0] r_snap_y;
  logic [15:0] r_snap_z;
  logic [7:0]  r_scratch [16];

  logic        w_sclk;
  logic        w_cs;
  logic        w_mosi;
  logic        w_sclk_rise;
  logic        w_sclk_fall;
  logic        w_cs_fall;
  logic        w_cs_rise;
  logic        w_sample;
  logic [2:0]  w_cnt;
  logic [2:0]  w_state;
  logic [7:0]  w_byte;
  logic        w_last;
  logic [7:0]  w_rd_addr;
  logic [7:0]  w_rd_data;

  assign w_sclk      = r_sclk_sync[1];
  assign w_cs        = r_cs_sync[1];
  assign w_mosi      = r_mosi_sync[1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_cs_fall   = ~w_cs & r_cs_d;
  assign w_cs_rise   = w_cs & ~r_cs_d;
  // A CS fall coinciding with an SCLK rise starts the frame and consumes that bit as command bit 7
  assign w_state     = w_cs_fall ? S_CMD : r_state;
  assign w_cnt       = w_cs_fall ? 3'd0 : r_bit_cnt;
  assign w_sample    = w_sclk_rise & ~w_cs & (w_state != S_IDLE);
  assign w_byte      = {r_shift_in[6:0], w_mosi};
  assign w_last      = w_sample & (w_cnt == 3'd7);
  // The first read byte is addressed by the byte just completing; later ones by the running pointer
  assign w_rd_addr   = (w_state == S_ADDR) ? w_byte : r_addr;

  assign MISO     = r_miso;
  assign busy     = r_busy;
  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;

  // Register map read mux over the frame-start snapshot and scratch bytes
  always_comb begin
    w_rd_data = 8'h00;
    case (w_rd_addr)
      8'h00:   w_rd_data = DEVID;
      8'h01:   w_rd_data = 8'h1D;
      8'h02:   w_rd_data = 8'hF2;
      8'h0E:   w_rd_data = r_snap_x[7:0];
      8'h0F:   w_rd_data = r_snap_x[15:8];
      8'h10:   w_rd_data = r_snap_y[7:0];
      8'h11:   w_rd_data = r_snap_y[15:8];
      8'h12:   w_rd_data = r_snap_z[7:0];
      8'h13:   w_rd_data = r_snap_z[15:8];
      default: w_rd_data = (w_rd_addr[7:4] == 4'h2) ? r_scratch[w_rd_addr[3:0]] : 8'h00;
    endcase
  end

  // Synchronize the SPI pins and keep one-cycle-old copies for edge detection;
  // CS resets low so a frame already in progress at reset release is never picked up mid-way
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sclk_sync <= 2'b00;
      r_cs_sync   <= 2'b00;
      r_mosi_sync <= 2'b00;
      r_sclk_d    <= 1'b0;
      r_cs_d      <= 1'b0;
    end else begin
      r_sclk_sync <= {r_sclk_sync[0], SCLK};
      r_cs_sync   <= {r_cs_sync[0], CS};
      r_mosi_sync <= {r_mosi_sync[0], MOSI};
      r_sclk_d    <= w_sclk;
      r_cs_d      <= w_cs;
    end
  end

  // busy follows detected CS edges only, so it stays low until a genuine frame start
  always_ff @(posedge clk) begin
    if (reset) r_busy <= 1'b0;
    else r_busy <= w_cs_fall ? 1'b1 : w_cs_rise ? 1'b0 : r_busy;
  end

  // Frame decoder: bit sampling, FSM, address pointer, write strobe, scratch storage and MISO shifting
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_bit_cnt   <= 3'd0;
      r_shift_in  <= 8'h00;
      r_shift_out <= 8'h00;
      r_addr      <= 8'h00;
      r_write     <= 1'b0;
      r_miso      <= 1'b0;
      r_wr_valid  <= 1'b0;
      r_wr_addr   <= 8'h00;
      r_wr_data   <= 8'h00;
      r_snap_x    <= 16'h0000;
      r_snap_y    <= 16'h0000;
      r_snap_z    <= 16'h0000;
      for (int i = 0; i < 16; i++) r_scratch[i] <= 8'h00;
    end else begin
      r_wr_valid <= 1'b0;
      if (w_cs_rise) begin
        r_state   <= S_IDLE;
        r_bit_cnt <= 3'd0;
        r_miso    <= 1'b0;
      end else begin
        if (w_cs_fall) begin
          r_state   <= S_CMD;
          r_bit_cnt <= 3'd0;
          r_snap_x  <= X_value;
          r_snap_y  <= Y_value;
          r_snap_z  <= Z_value;
        end
        if (w_sample) begin
          r_shift_in <= w_byte;
          r_bit_cnt  <= w_cnt + 3'd1;
        end
        if (w_last) begin
          case (w_state)
            S_CMD: begin
              r_state <= (w_byte == CMD_READ || w_byte == CMD_WRITE) ? S_ADDR : S_IGNORE;
              r_write <= (w_byte == CMD_WRITE);
            end
            S_ADDR: begin
              r_state     <= r_write ? S_WDATA : S_RDATA;
              r_addr      <= r_write ? w_byte : w_byte + 8'd1;
              r_shift_out <= w_rd_data;
            end
            S_RDATA: begin
              r_shift_out <= w_rd_data;
              r_addr      <= r_addr + 8'd1;
            end
            S_WDATA: begin
              if (r_addr[7:4] == 4'h2) begin
                r_scratch[r_addr[3:0]] <= w_byte;
                r_wr_valid             <= 1'b1;
                r_wr_addr              <= r_addr;
                r_wr_data              <= w_byte;
              end
              r_addr <= r_addr + 8'd1;
            end
            default: ;
          endcase
        end
        if (r_state != S_RDATA) r_miso <= 1'b0;
        else if (w_sclk_fall) begin
          r_miso      <= r_shift_out[7];
          r_shift_out <= {r_shift_out[6:0], 1'b0};
        end
      end
    end
  end

endmodule
